// File: rtl/fmeter_pkg.sv
// Shared types for the zero-crossing frequency meter.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   det_state_t - hysteresis crossing detector state (UNK / NEG / POS)
//   ctl_state_t - result control FSM state (MEAS / DIV)
//   det_next()  - next detector state for one consumed sample
package fmeter_pkg;

    typedef enum logic [1:0] {
        DET_UNK = 2'd0,
        DET_NEG = 2'd1,
        DET_POS = 2'd2
    } det_state_t;

    typedef enum logic {
        FSM_MEAS = 1'b0,
        FSM_DIV  = 1'b1
    } ctl_state_t;

    // hi: sample >= +HYST, lo: sample <= -HYST (mutually exclusive).
    // Samples inside the dead band leave the state untouched, so noise
    // around zero never produces a spurious crossing.
    function automatic det_state_t det_next(input det_state_t cur,
                                            input logic       hi,
                                            input logic       lo);
        det_state_t nxt;
        nxt = cur;
        case (cur)
            DET_UNK: begin
                if (hi)      nxt = DET_POS;
                else if (lo) nxt = DET_NEG;
            end
            DET_NEG: if (hi) nxt = DET_POS;
            DET_POS: if (lo) nxt = DET_NEG;
            default: nxt = DET_UNK;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/seq_udiv.sv
// Restoring unsigned divider, one quotient bit per clk, saturation flag.
// Latency: done pulses QUO_W clk after the start edge; quo/ovf held until next start.
// Backpressure: none; start is accepted on any cycle and restarts a division in flight.
//
// Ports:
//   clk, rst_n     - clock, async active-low reset
//   start          - load num/den and begin dividing
//   num [NUM_W]    - dividend
//   den [DEN_W]    - divisor
//   done           - one-cycle pulse, quo/ovf valid from this cycle
//   quo [QUO_W]    - low QUO_W bits of floor(num/den)
//   ovf            - true quotient does not fit in QUO_W bits (incl. den=0)
module seq_udiv #(
    parameter int NUM_W = 45,
    parameter int DEN_W = 12,
    parameter int QUO_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             done,
    output logic [QUO_W-1:0] quo,
    output logic             ovf
);

    localparam int HI_W  = NUM_W - QUO_W;
    localparam int CMP_W = (HI_W > DEN_W) ? HI_W : DEN_W;
    localparam int CNT_W = $clog2(QUO_W + 1);

    logic [DEN_W-1:0] den_q;
    logic [DEN_W-1:0] rem_q;
    logic [QUO_W-1:0] lo_q;
    logic [QUO_W-1:0] quo_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             ovf_q;

    logic [HI_W-1:0]  num_hi;
    logic             start_ovf;
    logic [DEN_W:0]   trial;
    logic [DEN_W:0]   diff;
    logic             take;
    logic [DEN_W-1:0] rem_d;

    // The quotient fits in QUO_W bits exactly when the numerator bits above
    // the quotient window are below the divisor. That upper slice then seeds
    // the partial remainder and only QUO_W iterations are needed.
    always_comb begin
        num_hi    = num[NUM_W-1:QUO_W];
        start_ovf = CMP_W'(num_hi) >= CMP_W'(den);
    end

    always_comb begin
        trial = {rem_q, lo_q[QUO_W-1]};
        diff  = trial - {1'b0, den_q};
        take  = trial >= {1'b0, den_q};
        rem_d = take ? diff[DEN_W-1:0] : trial[DEN_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            den_q  <= '0;
            rem_q  <= '0;
            lo_q   <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                den_q  <= den;
                // On overflow the remainder seed would not fit; the
                // iterations still run so done keeps a fixed latency.
                rem_q  <= start_ovf ? '0 : DEN_W'(num_hi);
                lo_q   <= num[QUO_W-1:0];
                quo_q  <= '0;
                ovf_q  <= start_ovf;
                cnt_q  <= CNT_W'(QUO_W);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rem_q <= rem_d;
                lo_q  <= {lo_q[QUO_W-2:0], 1'b0};
                quo_q <= {quo_q[QUO_W-2:0], take};
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done = done_q;
    assign quo  = quo_q;
    assign ovf  = ovf_q;

endmodule

// File: rtl/zc_freq_meter.sv
// Gated zero-crossing frequency meter: freq = (N-1)*2^FREQ_DW/(t_last-t_first) per gate.
// Latency: valid FREQ_DW+1 clk after the gate-end sample (1 clk when nosig).
// Backpressure: none; samples taken whenever en=1, results are fire-and-forget pulses.
//
// Ports:
//   clk, rst_n   - clock, async active-low reset
//   en           - sample strobe, in is consumed only when en=1
//   in [DW]      - signed sinusoid samples
//   freq [FREQ_DW] - measured frequency word (f/fs * 2^FREQ_DW), held until next result
//   nosig        - fewer than two rising crossings in the last gate
//   valid        - one-cycle pulse marking a new freq/nosig
module zc_freq_meter
    import fmeter_pkg::*;
#(
    parameter int DW        = 12,
    parameter int FREQ_DW   = 32,
    parameter int GATE_LOG2 = 16,
    parameter int HYST      = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic signed [DW-1:0] in,
    output logic [FREQ_DW-1:0]  freq,
    output logic                nosig,
    output logic                valid
);

    // GATE_LOG2 is expected in 8..24 and HYST >= 1. A gate of at least 256
    // samples is longer than the FREQ_DW+1 cycle division, so a capture can
    // never land while a division is still running.

    localparam int CNT_W = GATE_LOG2 + 1;
    localparam int NUM_W = GATE_LOG2 + 1 + FREQ_DW;

    // Thresholds one bit wider than the sample so HYST up to 2^(DW-1)
    // compares without wrapping.
    localparam logic signed [DW:0] HYST_POS = (DW + 1)'(HYST);
    localparam logic signed [DW:0] HYST_NEG = -HYST_POS;

    // ------------------------------------------------------------------
    // Crossing detector
    // ------------------------------------------------------------------
    det_state_t      det_q;
    det_state_t      det_d;
    logic signed [DW:0] in_ext;
    logic            in_hi;
    logic            in_lo;
    logic            rise;

    always_comb begin
        in_ext = $signed({in[DW-1], in});
        in_hi  = in_ext >= HYST_POS;
        in_lo  = in_ext <= HYST_NEG;
        det_d  = det_next(det_q, in_hi, in_lo);
        rise   = en && (det_q == DET_NEG) && in_hi;
    end

    // Detector state deliberately carries across gate boundaries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            det_q <= DET_UNK;
        end else if (en) begin
            det_q <= det_d;
        end
    end

    // ------------------------------------------------------------------
    // Gate bookkeeping: sample index, crossing count, first/last crossing
    // ------------------------------------------------------------------
    logic [GATE_LOG2-1:0] s_q;
    logic [GATE_LOG2-1:0] tf_q;
    logic [GATE_LOG2-1:0] tl_q;
    logic [CNT_W-1:0]     n_q;

    logic                 gate_end;
    logic [CNT_W-1:0]     n_eff;
    logic [GATE_LOG2-1:0] tf_eff;
    logic [GATE_LOG2-1:0] tl_eff;
    logic                 cap_hi;
    logic                 cap_lo;

    // The "_eff" values include a crossing on the current sample, so a
    // crossing on the last sample of a gate still counts for that gate.
    always_comb begin
        gate_end = en && (s_q == '1);
        n_eff    = n_q + CNT_W'(rise);
        tf_eff   = (rise && (n_q == '0)) ? s_q : tf_q;
        tl_eff   = rise ? s_q : tl_q;
        cap_hi   = gate_end && (n_eff >= CNT_W'(2));
        cap_lo   = gate_end && (n_eff <  CNT_W'(2));
    end

    // s wraps naturally at 2^GATE_LOG2, so gates run back-to-back. t_first
    // and t_last are not cleared at the boundary: with N cleared, the next
    // crossing overwrites both before they are ever used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q  <= '0;
            n_q  <= '0;
            tf_q <= '0;
            tl_q <= '0;
        end else if (en) begin
            s_q  <= s_q + GATE_LOG2'(1);
            n_q  <= gate_end ? '0 : n_eff;
            tf_q <= tf_eff;
            tl_q <= tl_eff;
        end
    end

    // ------------------------------------------------------------------
    // Divider: (N-1) periods over (t_last - t_first) samples
    // ------------------------------------------------------------------
    logic [NUM_W-1:0]     div_num;
    logic [GATE_LOG2-1:0] div_den;
    logic                 div_start;
    logic                 div_done;
    logic [FREQ_DW-1:0]   div_quo;
    logic                 div_ovf;

    always_comb begin
        div_num = {n_eff - CNT_W'(1), {FREQ_DW{1'b0}}};
        div_den = tl_eff - tf_eff;
    end

    seq_udiv #(
        .NUM_W (NUM_W),
        .DEN_W (GATE_LOG2),
        .QUO_W (FREQ_DW)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (div_start),
        .num   (div_num),
        .den   (div_den),
        .done  (div_done),
        .quo   (div_quo),
        .ovf   (div_ovf)
    );

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    ctl_state_t ctl_q;
    ctl_state_t ctl_d;
    logic       nosig_pend_q;
    logic       ld_freq;
    logic       ld_nosig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_q <= FSM_MEAS;
        end else begin
            ctl_q <= ctl_d;
        end
    end

    always_comb begin
        ctl_d = ctl_q;
        case (ctl_q)
            FSM_MEAS: if (cap_hi)   ctl_d = FSM_DIV;
            FSM_DIV:  if (div_done) ctl_d = FSM_MEAS;
            default:                ctl_d = FSM_MEAS;
        endcase
    end

    always_comb begin
        div_start = 1'b0;
        ld_freq   = 1'b0;
        ld_nosig  = 1'b0;
        case (ctl_q)
            FSM_MEAS: begin
                div_start = cap_hi;
                ld_nosig  = nosig_pend_q;
            end
            FSM_DIV: begin
                ld_freq = div_done;
            end
            default: begin
                div_start = 1'b0;
            end
        endcase
    end

    // A gate with too few crossings is reported one clk after its last
    // sample; holding it for a cycle keeps all results on registered paths.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nosig_pend_q <= 1'b0;
        end else begin
            nosig_pend_q <= cap_lo;
        end
    end

    // ------------------------------------------------------------------
    // Result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq  <= '0;
            nosig <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= ld_freq | ld_nosig;
            if (ld_freq) begin
                freq  <= div_ovf ? '1 : div_quo;
                nosig <= 1'b0;
            end else if (ld_nosig) begin
                freq  <= '0;
                nosig <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_zc_freq_meter.sv
module tb_zc_freq_meter;

    localparam int DW        = 12;
    localparam int FREQ_DW   = 32;
    localparam int GATE_LOG2 = 12;
    localparam int HYST      = 64;
    localparam int GATE      = 1 << GATE_LOG2;
    localparam int LAT       = FREQ_DW + 1;
    localparam longint unsigned FMAX = (64'd1 << FREQ_DW) - 64'd1;
    localparam real PI = 3.14159265358979323846;

    logic                   clk   = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   en    = 1'b0;
    logic signed [DW-1:0]   in_s  = '0;
    logic [FREQ_DW-1:0]     freq;
    logic                   nosig;
    logic                   valid;

    zc_freq_meter #(
        .DW        (DW),
        .FREQ_DW   (FREQ_DW),
        .GATE_LOG2 (GATE_LOG2),
        .HYST      (HYST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .in    (in_s),
        .freq  (freq),
        .nosig (nosig),
        .valid (valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    typedef struct {
        longint unsigned edge_no;
        longint unsigned f;
        bit              ns;
    } exp_t;

    exp_t            exp_q[$];
    longint unsigned edge_cnt = 0;
    int              m_s      = 0;
    int              m_cross[$];
    int              m_sign   = 0;   // sign of last sample outside the dead band, 0 = none yet
    longint unsigned m_gate_end = 0;
    longint unsigned cur_f    = 0;
    bit              cur_ns   = 1'b0;

    // observations of the DUT used by literal checks
    int              dut_vcnt = 0;
    longint unsigned last_f   = 0;
    bit              last_ns  = 1'b0;
    longint unsigned last_ve  = 0;
    longint unsigned prev_ve  = 0;
    longint unsigned last_lat = 0;

    bit tog = 1'b0;

    task automatic consume(input int v);
        exp_t            e;
        int              n;
        longint unsigned d;
        if (v >= HYST) begin
            if (m_sign < 0) m_cross.push_back(m_s);
            m_sign = 1;
        end else if (v <= -HYST) begin
            m_sign = -1;
        end
        if (m_s == GATE - 1) begin
            n = m_cross.size();
            m_gate_end = edge_cnt;
            if (n < 2) begin
                e.edge_no = edge_cnt + 1;
                e.f       = 0;
                e.ns      = 1'b1;
            end else begin
                d         = longint'(m_cross[n-1] - m_cross[0]);
                e.f       = (longint'(n - 1) << FREQ_DW) / d;
                if (e.f > FMAX) e.f = FMAX;
                e.ns      = 1'b0;
                e.edge_no = edge_cnt + LAT;
            end
            exp_q.push_back(e);
            m_cross.delete();
            m_s = 0;
        end else begin
            m_s++;
        end
    endtask

    task automatic chk_out(input string name, input bit ev);
        logic [FREQ_DW-1:0] ef;
        ef = cur_f[FREQ_DW-1:0];
        n_checks++;
        if (valid !== ev || freq !== ef || nosig !== cur_ns) begin
            n_fail++;
            $display("FAIL %s edge %0d: got valid=%b freq=%0d nosig=%b, want valid=%b freq=%0d nosig=%b",
                     name, edge_cnt, valid, freq, nosig, ev, ef, cur_ns);
        end
    endtask

    task automatic chk_lit(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic chk_rng(input string name, input longint unsigned got,
                           input longint unsigned lo, input longint unsigned hi);
        n_checks++;
        if (got < lo || got > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, got, lo, hi);
        end
    endtask

    // Model advances on the active edge, DUT outputs are compared on the
    // following falling edge.
    initial begin : scoreboard
        exp_t e;
        bit   ev;
        forever begin
            @(posedge clk);
            edge_cnt++;
            if (!rst_n) begin
                m_s    = 0;
                m_sign = 0;
                m_cross.delete();
                exp_q.delete();
            end else if (en) begin
                consume(int'(in_s));
            end
            @(negedge clk);
            if (!rst_n) begin
                cur_f  = 0;
                cur_ns = 1'b0;
                chk_out("reset_out", 1'b0);
            end else begin
                ev = 1'b0;
                if (exp_q.size() > 0 && exp_q[0].edge_no == edge_cnt) begin
                    e      = exp_q.pop_front();
                    cur_f  = e.f;
                    cur_ns = e.ns;
                    ev     = 1'b1;
                end
                if (valid === 1'b1) begin
                    dut_vcnt++;
                    prev_ve  = last_ve;
                    last_ve  = edge_cnt;
                    last_f   = longint'(freq);
                    last_ns  = nosig;
                    last_lat = edge_cnt - m_gate_end;
                end
                if (ev) chk_out("result", 1'b1);
                else    chk_out("hold", 1'b0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic put(input int v, input bit e);
        en   = e;
        in_s = v[DW-1:0];
        @(posedge clk);
        #1;
    endtask

    function automatic int junk();
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    task automatic samp(input int v);
        put(v, 1'b1);
        if (tog) put(junk(), 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(junk(), 1'b0);
    endtask

    function automatic int sine(input int k, input int per, input int amp);
        real r;
        r = amp * $sin(2.0 * PI * real'(k % per) / real'(per));
        return int'(r);
    endfunction

    initial begin : stim
        int k;
        int v0;
        int per;
        int amp;
        int v;
        int pick [7];
        pick = '{-65, -64, -63, 0, 63, 64, 65};
        k = 0;

        repeat (3) @(posedge clk);
        #1;
        chk_lit("reset_valid", 64'(valid), 64'd0);
        chk_lit("reset_freq",  64'(freq),  64'd0);
        chk_lit("reset_nosig", 64'(nosig), 64'd0);
        rst_n = 1'b1;

        // DC input: no crossings in either gate
        v0 = dut_vcnt;
        for (int i = 0; i < 2 * GATE; i++) samp(500);
        idle(40);
        chk_lit("dc_count", 64'(dut_vcnt - v0), 64'd2);
        chk_lit("dc_nosig", 64'(last_ns), 64'd1);
        chk_lit("dc_freq",  last_f, 64'd0);

        // 100-sample period sine
        for (int i = 0; i < 2 * GATE; i++) begin samp(sine(k, 100, 1800)); k++; end
        idle(40);
        chk_rng("sine_freq", last_f, 64'd42949671, 64'd42949673);
        chk_lit("sine_nosig", 64'(last_ns), 64'd0);
        chk_lit("sine_latency", last_lat, 64'd33);

        // alternating +/-1000: one period every two samples
        for (int i = 0; i < 2 * GATE; i++) samp((i % 2 == 0) ? 1000 : -1000);
        idle(40);
        chk_lit("alt_freq",  last_f, 64'd2147483648);
        chk_lit("alt_nosig", 64'(last_ns), 64'd0);

        // same sine with en toggling, junk on the idle cycles
        tog = 1'b1;
        k   = 0;
        for (int i = 0; i < 2 * GATE; i++) begin samp(sine(k, 100, 1800)); k++; end
        tog = 1'b0;
        idle(40);
        chk_rng("tog_freq", last_f, 64'd42949671, 64'd42949673);
        chk_lit("tog_gate_clk", last_ve - prev_ve, 64'(2 * GATE));

        // noise inside the dead band
        v0 = dut_vcnt;
        for (int i = 0; i < 2 * GATE; i++) samp(int'($urandom_range(0, 126)) - 63);
        idle(40);
        chk_lit("noise_count", 64'(dut_vcnt - v0), 64'd2);
        chk_lit("noise_nosig", 64'(last_ns), 64'd1);
        chk_lit("noise_freq",  last_f, 64'd0);

        // random period/amplitude sine with additive noise
        per = int'($urandom_range(8, 400));
        amp = int'($urandom_range(100, 2000));
        for (int i = 0; i < 2 * GATE; i++) begin
            v = sine(i, per, amp) + int'($urandom_range(0, 80)) - 40;
            if (v > 2047)  v = 2047;
            if (v < -2048) v = -2048;
            samp(v);
        end
        idle(40);

        // values right at and around the hysteresis thresholds
        for (int i = 0; i < GATE; i++) begin
            if ($urandom_range(0, 7) == 0) samp(junk());
            else                           samp(pick[$urandom_range(0, 6)]);
        end
        idle(40);

        // reset while a division is in flight
        for (int i = 0; i < GATE; i++) begin samp(sine(k, 100, 1800)); k++; end
        idle(10);
        rst_n = 1'b0;
        v0 = dut_vcnt;
        idle(3);
        rst_n = 1'b1;
        for (int i = 0; i < GATE; i++) begin samp(sine(k, 100, 1800)); k++; end
        chk_lit("rst_div_novalid", 64'(dut_vcnt - v0), 64'd0);
        chk_lit("rst_div_freq0",   64'(freq),  64'd0);
        chk_lit("rst_div_nosig0",  64'(nosig), 64'd0);
        idle(40);
        chk_lit("rst_div_count", 64'(dut_vcnt - v0), 64'd1);
        chk_rng("rst_div_freq", last_f, 64'd42949671, 64'd42949673);

        chk_lit("pending_results", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/zc_freq_meter.md
ZC_FREQ_METER -- requirements
Module: zc_freq_meter

Interface
REQ-001 SHALL have parameter DW, default 12, meaning signed sample width.
REQ-002 SHALL have parameter FREQ_DW, default 32, meaning frequency-control-word width, using the same scaling as orthDds: word = f/fs * 2^FREQ_DW.
REQ-003 SHALL have parameter GATE_LOG2, default 16, meaning the gate window is 2^GATE_LOG2 enabled samples; legal range 8..24.
REQ-004 SHALL have parameter HYST, default 64, meaning the crossing hysteresis in LSBs; HYST >= 1.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit, the reset; asynchronous and active-low.
REQ-007 SHALL have port en, input, 1 bit, the sample-valid strobe; in is consumed only when en=1.
REQ-008 SHALL have port in, input, signed DW bits, the sinusoid samples (e.g. orthDds or fir output).
REQ-009 SHALL have port freq, output, FREQ_DW bits unsigned, the measured frequency word; held until the next result.
REQ-010 SHALL have port nosig, output, 1 bit, set with a result when fewer than 2 rising crossings occurred in the gate.
REQ-011 SHALL have port valid, output, 1 bit, a one-cycle pulse marking a new freq/nosig.

Function
REQ-012 SHALL run a crossing detector with states UNK, NEG, POS; every transition SHALL occur only on an en=1 sample.
REQ-013 SHALL move UNK->NEG on in <= -HYST, UNK->POS on in >= HYST, and POS->NEG on in <= -HYST; none of these is a crossing.
REQ-014 SHALL treat NEG->POS on in >= HYST as a rising crossing; samples with |in| < HYST SHALL cause no state change.
REQ-015 SHALL keep sample index s (GATE_LOG2 bits, 0..2^GATE_LOG2-1), incremented per en sample and wrapping to 0 after the last sample of the gate.
REQ-016 SHALL keep crossing count N (GATE_LOG2+1 bits), t_first = s at the first crossing in the gate, and t_last = s at the latest crossing.
REQ-017 SHALL, on the en sample with s = 2^GATE_LOG2-1 (gate end, crossing on that sample included), capture N, t_first and t_last, then clear N for the next gate.
REQ-018 SHALL NOT reset the detector state at gate boundaries, and gates SHALL run back-to-back with no dead samples.
REQ-019 SHALL, after a capture with N >= 2, compute freq = floor((N-1) * 2^FREQ_DW / (t_last - t_first)) with an unsigned sequential divider.
REQ-020 SHALL saturate the quotient at 2^FREQ_DW-1.
REQ-021 SHALL use a divider numerator (N-1)<<FREQ_DW of GATE_LOG2+1+FREQ_DW bits, produce one quotient bit per clk, and advance independently of en.
REQ-022 SHALL drive a control FSM with states MEAS and DIV: MEAS->DIV on capture with N >= 2, and DIV->MEAS when the divider reports done.
REQ-023 SHALL assert valid exactly FREQ_DW+1 clk cycles after the capture edge, with freq updated and nosig=0.
REQ-024 SHALL, on a capture with N < 2, stay in MEAS and assert valid on the next clk with freq=0 and nosig=1.
REQ-025 SHALL ensure gate length (>= 256 samples) exceeds divider latency, so a capture never occurs while in DIV; no result is ever dropped.

Reset
REQ-026 SHALL, while rst_n=0, set freq=0, nosig=0, valid=0, detector=UNK, s=0, N=0, t_first=t_last=0, FSM=MEAS, and clear the divider.
REQ-027 SHALL abort any partial gate or division on mid-operation reset and emit no valid for it; the first result after release arrives at the end of the first full gate.

Structure
REQ-028 SHALL define the detector-state and FSM-state enums in shared package fmeter_pkg.
REQ-029 SHALL place the restoring divider in sub-module seq_udiv, parameterised by numerator/denominator/quotient widths, with start/done handshake.

Verification (GATE_LOG2=12, HYST=64, DW=12, FREQ_DW=32, en=1 unless stated)
REQ-030 SHALL cover DC input in=500 for 2 gates -> valid pulses with freq=0, nosig=1.
REQ-031 SHALL cover a 100-sample-period sine, amplitude 1800 -> after the first full gate, freq=42949672 (±1 LSB), nosig=0, valid exactly 33 cycles after gate end.
REQ-032 SHALL cover an alternating +1000/-1000 input -> freq=2147483648 (2^31), nosig=0.
REQ-033 SHALL cover the REQ-031 sine with en toggling 1/0 each cycle, samples applied only on en=1 -> identical freq to REQ-031; the gate takes 8192 clk.
REQ-034 SHALL cover noise within ±63 around 0 -> no crossings, nosig=1; and rst_n pulsed low during DIV -> no valid, outputs 0 until the next full gate.
